// File: rtl/game_pkg.sv
// Shared encodings and default frame counts for the hit resolution logic.
package game_pkg;

    // Width of the per-defender stun countdown.
    localparam int STUN_CNT_W = 4;

    // Default stun durations in 60 Hz game frames.
    localparam int DEFAULT_HITSTUN_FRAMES   = 10;
    localparam int DEFAULT_BLOCKSTUN_FRAMES = 6;

    // One-cycle event code handed to the status stage.
    typedef enum logic [1:0] {
        STUN_NONE  = 2'b00,
        STUN_HIT   = 2'b01,
        STUN_BLOCK = 2'b10
    } stunmode_t;

    // Per-defender stun state.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_HITSTUN   = 2'b01,
        ST_BLOCKSTUN = 2'b10
    } stun_state_t;

endpackage

// File: rtl/hit_resolver_stun_fsm.sv
// Per-defender stun FSM: qualifies incoming hits, chooses hit or block,
// counts stun frames down, and remembers that the attacker already connected.
module stun_fsm
    import game_pkg::*;
#(
    parameter int HITSTUN_FRAMES   = DEFAULT_HITSTUN_FRAMES,
    parameter int BLOCKSTUN_FRAMES = DEFAULT_BLOCKSTUN_FRAMES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  freeze,
    input  logic                  attack_active,
    input  logic                  attack_hit,
    input  logic                  blocking,
    input  logic                  block_avail,
    output logic [1:0]            stunmode,
    output logic                  stunned,
    output logic [STUN_CNT_W-1:0] stun_left
);

    // Stun durations must be loadable into the countdown and nonzero.
    if (HITSTUN_FRAMES < 1 || HITSTUN_FRAMES > 15) begin : g_bad_hitstun
        $error("HITSTUN_FRAMES must be in 1..15");
    end
    if (BLOCKSTUN_FRAMES < 1 || BLOCKSTUN_FRAMES > 15) begin : g_bad_blockstun
        $error("BLOCKSTUN_FRAMES must be in 1..15");
    end

    localparam logic [STUN_CNT_W-1:0] HIT_LOAD   = STUN_CNT_W'(HITSTUN_FRAMES);
    localparam logic [STUN_CNT_W-1:0] BLOCK_LOAD = STUN_CNT_W'(BLOCKSTUN_FRAMES);

    stun_state_t state;
    stunmode_t   stunmode_q;
    logic        hit_landed;
    logic        qualify;

    // A hit only counts once per attack, outside freeze, against an idle defender.
    assign qualify = attack_active && attack_hit && !freeze
                     && (state == ST_IDLE) && !hit_landed;

    // State, countdown, event pulse and hit-landed latch all advance together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            stun_left  <= '0;
            stunmode_q <= STUN_NONE;
            hit_landed <= 1'b0;
        end else begin
            stunmode_q <= STUN_NONE;

            if (!attack_active) begin
                hit_landed <= 1'b0;
            end else if (qualify) begin
                hit_landed <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    stun_left <= '0;
                    if (qualify) begin
                        if (blocking && block_avail) begin
                            state      <= ST_BLOCKSTUN;
                            stun_left  <= BLOCK_LOAD;
                            stunmode_q <= STUN_BLOCK;
                        end else begin
                            state      <= ST_HITSTUN;
                            stun_left  <= HIT_LOAD;
                            stunmode_q <= STUN_HIT;
                        end
                    end
                end
                ST_HITSTUN, ST_BLOCKSTUN: begin
                    if (frame_tick) begin
                        if (stun_left <= STUN_CNT_W'(1)) begin
                            state     <= ST_IDLE;
                            stun_left <= '0;
                        end else begin
                            stun_left <= stun_left - STUN_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    stun_left <= '0;
                end
            endcase
        end
    end

    assign stunmode = stunmode_q;
    assign stunned  = (state != ST_IDLE);

endmodule

// File: rtl/hit_resolver.sv
// Top-level hit resolver: two stun FSMs, each defender driven by the
// opposing player's attack signals.
module hit_resolver
    import game_pkg::*;
#(
    parameter int HITSTUN_FRAMES   = DEFAULT_HITSTUN_FRAMES,
    parameter int BLOCKSTUN_FRAMES = DEFAULT_BLOCKSTUN_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       freeze,
    input  logic       p1_attack_active,
    input  logic       p2_attack_active,
    input  logic       p1_attack_hit,
    input  logic       p2_attack_hit,
    input  logic       p1_blocking,
    input  logic       p2_blocking,
    input  logic       p1_block_avail,
    input  logic       p2_block_avail,
    output logic [1:0] p1_stunmode,
    output logic [1:0] p2_stunmode,
    output logic       p1_stunned,
    output logic       p2_stunned,
    output logic [3:0] p1_stun_left,
    output logic [3:0] p2_stun_left
);

    stun_fsm #(
        .HITSTUN_FRAMES   (HITSTUN_FRAMES),
        .BLOCKSTUN_FRAMES (BLOCKSTUN_FRAMES)
    ) u_p1_defender (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .freeze        (freeze),
        .attack_active (p2_attack_active),
        .attack_hit    (p2_attack_hit),
        .blocking      (p1_blocking),
        .block_avail   (p1_block_avail),
        .stunmode      (p1_stunmode),
        .stunned       (p1_stunned),
        .stun_left     (p1_stun_left)
    );

    stun_fsm #(
        .HITSTUN_FRAMES   (HITSTUN_FRAMES),
        .BLOCKSTUN_FRAMES (BLOCKSTUN_FRAMES)
    ) u_p2_defender (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .freeze        (freeze),
        .attack_active (p1_attack_active),
        .attack_hit    (p1_attack_hit),
        .blocking      (p2_blocking),
        .block_avail   (p2_block_avail),
        .stunmode      (p2_stunmode),
        .stunned       (p2_stunned),
        .stun_left     (p2_stun_left)
    );

endmodule

// File: tb/tb_hit_resolver.sv
// Directed testbench for hit_resolver with hand-computed expectations.
module tb_hit_resolver;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       freeze;
    logic       p1_attack_active;
    logic       p2_attack_active;
    logic       p1_attack_hit;
    logic       p2_attack_hit;
    logic       p1_blocking;
    logic       p2_blocking;
    logic       p1_block_avail;
    logic       p2_block_avail;
    logic [1:0] p1_stunmode;
    logic [1:0] p2_stunmode;
    logic       p1_stunned;
    logic       p2_stunned;
    logic [3:0] p1_stun_left;
    logic [3:0] p2_stun_left;

    int tests_run;
    int tests_failed;
    int pulse_count;

    hit_resolver dut (
        .clk              (clk),
        .reset            (reset),
        .frame_tick       (frame_tick),
        .freeze           (freeze),
        .p1_attack_active (p1_attack_active),
        .p2_attack_active (p2_attack_active),
        .p1_attack_hit    (p1_attack_hit),
        .p2_attack_hit    (p2_attack_hit),
        .p1_blocking      (p1_blocking),
        .p2_blocking      (p2_blocking),
        .p1_block_avail   (p1_block_avail),
        .p2_block_avail   (p2_block_avail),
        .p1_stunmode      (p1_stunmode),
        .p2_stunmode      (p2_stunmode),
        .p1_stunned       (p1_stunned),
        .p2_stunned       (p2_stunned),
        .p1_stun_left     (p1_stun_left),
        .p2_stun_left     (p2_stun_left)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Drive p2 attacking p1 (or stop attacking).
    task automatic applyStimulus(input logic active, input logic hit);
        p2_attack_active = active;
        p2_attack_hit    = hit;
    endtask

    // Issue n single-cycle frame ticks separated by idle cycles.
    task automatic runFrames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            stepClk();
            frame_tick = 1'b0;
            stepClk();
        end
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        pulse_count      = 0;
        reset            = 1'b0;
        frame_tick       = 1'b0;
        freeze           = 1'b0;
        p1_attack_active = 1'b0;
        p2_attack_active = 1'b0;
        p1_attack_hit    = 1'b0;
        p2_attack_hit    = 1'b0;
        p1_blocking      = 1'b0;
        p2_blocking      = 1'b0;
        p1_block_avail   = 1'b0;
        p2_block_avail   = 1'b0;

        // Reset state
        stepClk();
        stepClk();
        checkOutput("rst_p1_mode", p1_stunmode, 0);
        checkOutput("rst_p2_mode", p2_stunmode, 0);
        checkOutput("rst_p1_stunned", p1_stunned, 0);
        checkOutput("rst_p2_stunned", p2_stunned, 0);
        checkOutput("rst_p1_left", p1_stun_left, 0);
        checkOutput("rst_p2_left", p2_stun_left, 0);

        // Plain hit on the first edge after reset release
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1);
        stepClk();
        checkOutput("hit_p1_mode", p1_stunmode, 1);
        checkOutput("hit_p1_stunned", p1_stunned, 1);
        checkOutput("hit_p1_left", p1_stun_left, 10);
        checkOutput("hit_p2_mode", p2_stunmode, 0);
        applyStimulus(1'b0, 1'b0);
        stepClk();
        checkOutput("hit_pulse_end", p1_stunmode, 0);
        checkOutput("hit_left_hold", p1_stun_left, 10);
        runFrames(9);
        checkOutput("hit_left_1", p1_stun_left, 1);
        checkOutput("hit_still_stunned", p1_stunned, 1);
        frame_tick = 1'b1;
        stepClk();
        frame_tick = 1'b0;
        checkOutput("hit_expired", p1_stunned, 0);
        checkOutput("hit_left_0", p1_stun_left, 0);

        // Blocked hit with meter available
        p1_blocking    = 1'b1;
        p1_block_avail = 1'b1;
        applyStimulus(1'b1, 1'b1);
        stepClk();
        checkOutput("blk_p1_mode", p1_stunmode, 2);
        checkOutput("blk_p1_left", p1_stun_left, 6);
        applyStimulus(1'b0, 1'b0);
        stepClk();
        checkOutput("blk_pulse_end", p1_stunmode, 0);
        runFrames(6);
        checkOutput("blk_expired", p1_stunned, 0);

        // Blocking with empty meter is a clean hit
        p1_block_avail = 1'b0;
        applyStimulus(1'b1, 1'b1);
        stepClk();
        checkOutput("noblk_p1_mode", p1_stunmode, 1);
        checkOutput("noblk_p1_left", p1_stun_left, 10);
        applyStimulus(1'b0, 1'b0);
        runFrames(10);
        checkOutput("noblk_expired", p1_stunned, 0);
        p1_blocking = 1'b0;

        // Held attack over 30 clocks with three frame ticks: one pulse only
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) begin
            frame_tick = ((i % 10) == 9);
            stepClk();
            if (p1_stunmode != 2'b00) pulse_count++;
        end
        frame_tick = 1'b0;
        checkOutput("held_pulses", pulse_count, 1);
        checkOutput("held_left", p1_stun_left, 7);
        applyStimulus(1'b0, 1'b0);
        stepClk();
        runFrames(7);
        checkOutput("held_expired", p1_stunned, 0);
        applyStimulus(1'b1, 1'b1);
        stepClk();
        if (p1_stunmode != 2'b00) pulse_count++;
        checkOutput("rearm_pulses", pulse_count, 2);
        checkOutput("rearm_mode", p1_stunmode, 1);
        applyStimulus(1'b0, 1'b0);
        runFrames(10);

        // Trade: both players hit on the same edge
        p1_attack_active = 1'b1;
        p1_attack_hit    = 1'b1;
        applyStimulus(1'b1, 1'b1);
        stepClk();
        checkOutput("trade_p1_mode", p1_stunmode, 1);
        checkOutput("trade_p2_mode", p2_stunmode, 1);
        checkOutput("trade_p2_left", p2_stun_left, 10);
        p1_attack_active = 1'b0;
        p1_attack_hit    = 1'b0;
        applyStimulus(1'b0, 1'b0);
        runFrames(10);
        checkOutput("trade_p1_idle", p1_stunned, 0);
        checkOutput("trade_p2_idle", p2_stunned, 0);

        // Freeze blocks new hits
        freeze = 1'b1;
        applyStimulus(1'b1, 1'b1);
        stepClk();
        checkOutput("frz_mode", p1_stunmode, 0);
        stepClk();
        checkOutput("frz_stunned", p1_stunned, 0);

        // Unfreezing lets the still-held attack connect
        freeze = 1'b0;
        stepClk();
        checkOutput("unfrz_mode", p1_stunmode, 1);
        applyStimulus(1'b0, 1'b0);

        // Countdown continues under freeze
        freeze = 1'b1;
        runFrames(6);
        checkOutput("frz_countdown", p1_stun_left, 4);
        checkOutput("frz_still_stunned", p1_stunned, 1);
        freeze = 1'b0;

        // Asynchronous reset mid-stun
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_left", p1_stun_left, 0);
        checkOutput("arst_stunned", p1_stunned, 0);
        checkOutput("arst_mode", p1_stunmode, 0);
        stepClk();
        reset = 1'b1;
        stepClk();
        checkOutput("post_rst_mode", p1_stunmode, 0);
        checkOutput("post_rst_stunned", p1_stunned, 0);
        stepClk();
        checkOutput("post_rst_mode2", p1_stunmode, 0);

        // Frame tick coincident with the hit does not decrement the fresh load
        applyStimulus(1'b1, 1'b1);
        frame_tick = 1'b1;
        stepClk();
        frame_tick = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("coinc_left", p1_stun_left, 10);
        checkOutput("coinc_mode", p1_stunmode, 1);
        runFrames(1);
        checkOutput("coinc_left_next", p1_stun_left, 9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hit_resolver.md
HIT_RESOLVER -- requirements
Module: hit_resolver

Interface
REQ-001 Parameter HITSTUN_FRAMES, default 10, frames a struck defender stays in hitstun.
REQ-002 Parameter BLOCKSTUN_FRAMES, default 6, frames a blocking defender stays in blockstun.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (reset=0 resets immediately).
REQ-005 frame_tick  in  1  one-clk enable pulse per 60 Hz game frame.
REQ-006 freeze  in  1  round over or paused; when high, no new hits are accepted.
REQ-007 p1_attack_active / p2_attack_active  in  1 each  attacker's hitbox is in its active frames.
REQ-008 p1_attack_hit / p2_attack_hit  in  1 each  attacker's hitbox overlaps the opponent's hurtbox.
REQ-009 p1_blocking / p2_blocking  in  1 each  defender is holding block.
REQ-010 p1_block_avail / p2_block_avail  in  1 each  defender's block meter is nonzero.
REQ-011 p1_stunmode / p2_stunmode  out  2 each  event code for the status stage: 00 none, 01 hit, 10 blocked.
REQ-012 p1_stunned / p2_stunned  out  1 each  defender is locked in hitstun or blockstun.
REQ-013 p1_stun_left / p2_stun_left  out  4 each  remaining stun frames.

Function
REQ-014 One identical stun FSM per defender, states IDLE, HITSTUN, BLOCKSTUN; the p1 FSM is driven by p2's attack signals and vice versa.
REQ-015 A hit qualifies on a clk edge when attack_active=1, attack_hit=1, freeze=0, the defender FSM is IDLE, and the attacker's hit_landed latch is 0.
REQ-016 On a qualifying hit with defender blocking=1 and block_avail=1: next state BLOCKSTUN, stun_left loaded with BLOCKSTUN_FRAMES, stunmode=10 for exactly one clk.
REQ-017 On any other qualifying hit: next state HITSTUN, stun_left loaded with HITSTUN_FRAMES, stunmode=01 for exactly one clk.
REQ-018 Latency is one clk: stunmode pulses on the cycle after the qualifying edge, and stunned rises in the same cycle.
REQ-019 stunmode is 00 on every other cycle, so the downstream status shift registers move exactly one position per event.
REQ-020 The hit_landed latch sets on a qualifying hit and clears only when attack_active=0, giving one hit per attack.
REQ-021 Hits arriving while the defender is in HITSTUN or BLOCKSTUN are ignored and do not set hit_landed, so a later active frame may still connect.
REQ-022 In a stun state, stun_left decrements by 1 on each frame_tick; on a frame_tick with stun_left=1 it goes to 0, the FSM returns to IDLE, and stunned falls on the next cycle.
REQ-023 A frame_tick coincident with a qualifying hit does not decrement the freshly loaded count.
REQ-024 Simultaneous qualifying hits by both players (trade) are both accepted in the same cycle, and both stunmode outputs pulse together.
REQ-025 freeze does not abort an active stun, and countdown continues.
REQ-026 stunned = (state != IDLE), and stun_left is 0 in IDLE.
REQ-027 HITSTUN_FRAMES and BLOCKSTUN_FRAMES shall be 1..15; a width check fails elaboration otherwise.

Reset
REQ-028 While reset=0: both FSMs IDLE, stun_left=0, stunned=0, stunmode=00, hit_landed latches cleared.
REQ-029 Reset asserted mid-stun or during a stunmode pulse aborts it immediately, with no residual pulse after release.
REQ-030 The first qualifying hit is accepted on the first clk edge after reset rises.

Structure
REQ-031 Shared package game_pkg holds the stunmode encodings (STUN_NONE=00, STUN_HIT=01, STUN_BLOCK=10), the FSM state encoding, and default frame constants.
REQ-032 One sub-module, stun_fsm (per-defender FSM, counter, attacker hit_landed latch), is instantiated twice; hit_resolver contains only cross-wiring.

Verification
REQ-033 Reset release, then p2 attack_active=1 with hit=1 and p1 blocking=0: p1_stunmode=01 for one clk, p1_stunned=1, p1_stun_left=10; after 10 frame_ticks p1_stunned=0.
REQ-034 Same with p1 blocking=1 and block_avail=1: p1_stunmode=10 for one clk and stun_left=6; with block_avail=0 the result is 01 instead.
REQ-035 attack_active and hit held high for 30 clks across 3 frame_ticks: exactly one stunmode pulse; drop active and reassert after stun expires gives a second pulse.
REQ-036 Both players hit on the same edge: p1_stunmode=01 and p2_stunmode=01 in the same cycle.
REQ-037 freeze=1 with a valid hit gives no pulse; reset=0 asserted at stun_left=4 clears all outputs asynchronously, and no pulse follows release.
REQ-038 frame_tick coincident with a hit: stun_left reads 10, not 9, the cycle after.
